dcm_reset_ctrl: RTL and testbench
=================================

Name: dcm_reset_ctrl

Overview:
Sequences the reset of the board DCM_SP and gates the design-wide reset on a verified lock. Pulses DCM RST for the required minimum width, waits for LOCKED with a timeout, then lets the clock settle before releasing sys_rst to the DDR controller and EPD logic. Monitors lock during operation and re-runs the sequence on loss, entering a fault state after repeated consecutive failures. Runs on the 33 MHz buffered input clock, which remains valid while the DCM is unlocked.

Parameters:
RST_PULSE_CYCLES, 4, cycles dcm_rst is held high per attempt (DCM_SP requires at least 3 CLKIN cycles)
LOCK_TIMEOUT, 33000, cycles allowed in WAIT_LOCK before an attempt fails (about 1 ms)
SETTLE_CYCLES, 256, cycles lock must hold continuously before sys_rst is released
MAX_RETRIES, 7, consecutive failed attempts before FAULT (1..15)

Ports:
clk  in  1  33 MHz buffered input clock
rst  in  1  asynchronous, active-high reset
dcm_locked  in  1  DCM LOCKED; asynchronous, 2-FF synchronised internally (locked_s)
dcm_status  in  8  DCM STATUS; only bit 2 (CLKFX stopped) is used, 2-FF synchronised (fxstop_s)
restart  in  1  single-cycle request to re-run the full sequence; clears the retry count
dcm_rst  out  1  drives DCM RST
sys_rst  out  1  active-high reset for downstream logic
clk_ok  out  1  high only in RUN
fault  out  1  high only in FAULT
retry_count  out  4  consecutive failed attempts

Behaviour:
- Reset values while rst=1: state=RESET_DCM, cnt=0, dcm_rst=1, sys_rst=1, clk_ok=0, fault=0, retry_count=0, sync flops=0. Assertion is asynchronous; deassertion follows the normal sequence.
- Outputs are registered and change on the same edge as the state transition.
- good = locked_s and not fxstop_s.
- dcm_rst=1 in RESET_DCM and FAULT. sys_rst=0 only in RUN. clk_ok=1 only in RUN. fault=1 only in FAULT.
- RESET_DCM: cnt counts 0..RST_PULSE_CYCLES-1. At the last count, go to WAIT_LOCK and set cnt=0.
- WAIT_LOCK:
  - If good, go to SETTLE and set cnt=0.
  - Else if cnt==LOCK_TIMEOUT-1, the attempt fails (see Fail rule).
  - Otherwise cnt++.
- SETTLE:
  - If not good, the attempt fails (a single-cycle drop is enough).
  - Else if cnt==SETTLE_CYCLES-1, go to RUN and clear retry_count.
  - Otherwise cnt++.
- RUN: if not good, the attempt fails. sys_rst rises at the edge after the loss of good is seen (3 clk worst case from the dcm_locked pin).
- Fail rule:
  - new = retry_count+1, saturating at 15; retry_count <= new.
  - If new >= MAX_RETRIES, go to FAULT; else go to RESET_DCM with cnt=0.
- FAULT: dcm_rst stays held. Exit only via rst or restart.
- restart, in any state: go to RESET_DCM, cnt=0, retry_count=0. It takes priority over every other transition in the same cycle, including a simultaneous lock loss or timeout, and does not count as a failure.
- Counter width is clog2(max(LOCK_TIMEOUT, SETTLE_CYCLES, RST_PULSE_CYCLES)).
- dcm_status bits other than bit 2 are ignored. Bit 1 (CLKIN stopped) cannot be observed, because this block is clocked by CLKIN.

Test Plan:
(Bench parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT=100, SETTLE_CYCLES=16, MAX_RETRIES=3; cycles counted from the first clk edge after rst falls.)
- Nominal lock: dcm_locked rises at cycle 20 -> dcm_rst high cycles 0–3 and low from cycle 4; SETTLE entered 2–3 cycles after the rise; sys_rst falls and clk_ok rises exactly 16 cycles after SETTLE entry; retry_count=0.
- Never locks -> three dcm_rst pulses of 4 cycles each, spaced 104 cycles apart; retry_count 1, 2, 3; fault=1 and dcm_rst held high from cycle ~312; sys_rst stays 1.
- Lock loss in RUN: dcm_locked low for 10 cycles -> sys_rst=1 and clk_ok=0 within 3 cycles, a 4-cycle dcm_rst pulse, retry_count=1; after relock and settle -> RUN with retry_count=0.
- One-cycle glitch on dcm_locked at SETTLE cnt=8 -> back to RESET_DCM, retry_count=1, sys_rst never deasserts; the same test with dcm_status[2]=1 instead gives an identical response.
- From FAULT, a restart pulse -> next edge: fault=0, retry_count=0, dcm_rst high for 4 cycles, then normal lock; restart asserted together with a lock loss in RUN -> retry_count stays 0.
- rst asserted mid-SETTLE between clock edges -> dcm_rst=1, sys_rst=1, clk_ok=0 immediately without a clock edge; after release the sequence restarts from RESET_DCM.

Source files
------------

// File: rtl/dcm_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcm_reset_ctrl
// Description : Sequences the DCM_SP reset, waits for a verified lock, lets
//               the clock settle, then releases the design-wide reset. Lock
//               loss re-runs the sequence. Repeated consecutive failures
//               park the block in FAULT with the DCM held in reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dcm_reset_ctrl #(
    parameter int RST_PULSE_CYCLES = 4,
    parameter int LOCK_TIMEOUT     = 33000,
    parameter int SETTLE_CYCLES    = 256,
    parameter int MAX_RETRIES      = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dcm_locked,
    input  logic [7:0] dcm_status,
    input  logic       restart,
    output logic       dcm_rst,
    output logic       sys_rst,
    output logic       clk_ok,
    output logic       fault,
    output logic [3:0] retry_count
);

    localparam int MAX_A   = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
    localparam int MAX_CNT = (MAX_A > RST_PULSE_CYCLES) ? MAX_A : RST_PULSE_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] C_PULSE_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       C_MAX_RETRY   = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RESET_DCM = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    logic             locked_meta_q;
    logic             locked_s_q;
    logic             fxstop_meta_q;
    logic             fxstop_s_q;
    logic             good;
    logic             status_unused;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [3:0]       retry_q;
    logic [3:0]       retry_d;
    logic [3:0]       retry_inc;
    logic             fail;

    logic             dcm_rst_q;
    logic             sys_rst_q;
    logic             clk_ok_q;
    logic             fault_q;

    // Two-flop synchronisers for the asynchronous DCM LOCKED and CLKFX-stopped pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_meta_q <= 1'b0;
            locked_s_q    <= 1'b0;
            fxstop_meta_q <= 1'b0;
            fxstop_s_q    <= 1'b0;
        end else begin
            locked_meta_q <= dcm_locked;
            locked_s_q    <= locked_meta_q;
            fxstop_meta_q <= dcm_status[2];
            fxstop_s_q    <= fxstop_meta_q;
        end
    end

    // Only CLKFX-stopped matters; CLKIN-stopped is unobservable from this clock domain
    assign status_unused = ^{dcm_status[7:3], dcm_status[1:0]};
    assign good          = locked_s_q & ~fxstop_s_q;

    // Next-state logic: a failed attempt bumps the saturating retry count, restart overrides all
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        fail      = 1'b0;
        retry_inc = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;

        case (state_q)
            ST_RESET_DCM: begin
                if (cnt_q == C_PULSE_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (good) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == C_LOCK_LAST) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!good) begin
                    fail = 1'b1;
                end else if (cnt_q == C_SETTLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!good) begin
                    fail = 1'b1;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_RESET_DCM;
                cnt_d   = '0;
            end
        endcase

        if (fail) begin
            retry_d = retry_inc;
            cnt_d   = '0;
            state_d = (retry_inc >= C_MAX_RETRY) ? ST_FAULT : ST_RESET_DCM;
        end

        if (restart) begin
            state_d = ST_RESET_DCM;
            cnt_d   = '0;
            retry_d = '0;
        end
    end

    // State, counters and registered outputs all update on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RESET_DCM;
            cnt_q     <= '0;
            retry_q   <= '0;
            dcm_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            clk_ok_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            dcm_rst_q <= (state_d == ST_RESET_DCM) || (state_d == ST_FAULT);
            sys_rst_q <= (state_d != ST_RUN);
            clk_ok_q  <= (state_d == ST_RUN);
            fault_q   <= (state_d == ST_FAULT);
        end
    end

    assign dcm_rst     = dcm_rst_q;
    assign sys_rst     = sys_rst_q;
    assign clk_ok      = clk_ok_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_dcm_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcm_reset_ctrl
// Description : Directed, table-driven bench for dcm_reset_ctrl with small
//               parameters (pulse 4, timeout 100, settle 16, retries 3).
//               Edge numbers count posedges after rst is released (edge 0
//               is the first); outputs are sampled 2 ns after each edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcm_reset_ctrl;

    logic       clk;
    logic       rst;
    logic       dcm_locked;
    logic [7:0] dcm_status;
    logic       restart;
    logic       dcm_rst;
    logic       sys_rst;
    logic       clk_ok;
    logic       fault;
    logic [3:0] retry_count;

    int n_cmp = 0;
    int n_err = 0;
    int last_edge = -1;

    typedef struct {
        int         e;
        logic       dcm;
        logic       sys;
        logic       ok;
        logic       flt;
        logic [3:0] rty;
        logic       lk;
        logic [7:0] st;
        logic       rs;
    } vec_t;

    vec_t vecs[$];

    dcm_reset_ctrl #(
        .RST_PULSE_CYCLES(4),
        .LOCK_TIMEOUT    (100),
        .SETTLE_CYCLES   (16),
        .MAX_RETRIES     (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dcm_locked (dcm_locked),
        .dcm_status (dcm_status),
        .restart    (restart),
        .dcm_rst    (dcm_rst),
        .sys_rst    (sys_rst),
        .clk_ok     (clk_ok),
        .fault      (fault),
        .retry_count(retry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if the directed sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int idx, input string fld,
                       input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] %s: got %0d, expected %0d", tag, idx, fld, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int idx, input logic d, input logic s,
                           input logic o, input logic f, input logic [3:0] r);
        chk(tag, idx, "dcm_rst", {3'b0, dcm_rst}, {3'b0, d});
        chk(tag, idx, "sys_rst", {3'b0, sys_rst}, {3'b0, s});
        chk(tag, idx, "clk_ok", {3'b0, clk_ok}, {3'b0, o});
        chk(tag, idx, "fault", {3'b0, fault}, {3'b0, f});
        chk(tag, idx, "retry_count", retry_count, r);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        last_edge++;
    endtask

    task automatic go(input int e);
        while (last_edge < e) step();
    endtask

    task automatic release_rst();
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        last_edge = -1;
    endtask

    task automatic add(input int e, input logic d, input logic s, input logic o, input logic f,
                       input logic [3:0] r, input logic lk, input logic [7:0] st, input logic rs);
        vec_t v;
        v.e = e; v.dcm = d; v.sys = s; v.ok = o; v.flt = f; v.rty = r;
        v.lk = lk; v.st = st; v.rs = rs;
        vecs.push_back(v);
    endtask

    initial begin
        rst        = 1'b1;
        dcm_locked = 1'b0;
        dcm_status = 8'h00;
        restart    = 1'b0;

        // Table: check outputs after edge e, then drive the listed inputs
        //   e    dcm sys ok flt rty   locked status restart
        // nominal lock
        add(  0,  1,  1, 0, 0, 0,    0, 8'h00, 0);
        add(  2,  1,  1, 0, 0, 0,    0, 8'h00, 0);
        add(  3,  0,  1, 0, 0, 0,    0, 8'h00, 0);
        add( 19,  0,  1, 0, 0, 0,    1, 8'h00, 0);
        add( 21,  0,  1, 0, 0, 0,    1, 8'h00, 0);
        add( 37,  0,  1, 0, 0, 0,    1, 8'h00, 0);
        add( 38,  0,  0, 1, 0, 0,    1, 8'h00, 0);
        // lock lost in RUN for 10 cycles
        add( 50,  0,  0, 1, 0, 0,    0, 8'h00, 0);
        add( 52,  0,  0, 1, 0, 0,    0, 8'h00, 0);
        add( 53,  1,  1, 0, 0, 1,    0, 8'h00, 0);
        add( 56,  1,  1, 0, 0, 1,    0, 8'h00, 0);
        add( 57,  0,  1, 0, 0, 1,    0, 8'h00, 0);
        add( 60,  0,  1, 0, 0, 1,    1, 8'h00, 0);
        add( 78,  0,  1, 0, 0, 1,    1, 8'h00, 0);
        add( 79,  0,  0, 1, 0, 0,    1, 8'h00, 0);
        // restart, then one-cycle LOCKED glitch at SETTLE cnt=8
        add( 80,  0,  0, 1, 0, 0,    1, 8'h00, 1);
        add( 81,  1,  1, 0, 0, 0,    1, 8'h00, 0);
        add( 85,  0,  1, 0, 0, 0,    1, 8'h00, 0);
        add( 92,  0,  1, 0, 0, 0,    0, 8'h00, 0);
        add( 93,  0,  1, 0, 0, 0,    1, 8'h00, 0);
        add( 94,  0,  1, 0, 0, 0,    1, 8'h00, 0);
        add( 95,  1,  1, 0, 0, 1,    1, 8'h00, 0);
        add(110,  0,  1, 0, 0, 1,    1, 8'h00, 0);
        add(115,  0,  1, 0, 0, 1,    1, 8'h00, 0);
        add(116,  0,  0, 1, 0, 0,    1, 8'h00, 0);
        // restart, then one-cycle CLKFX-stopped glitch; other status bits set
        add(120,  0,  0, 1, 0, 0,    1, 8'hFB, 1);
        add(121,  1,  1, 0, 0, 0,    1, 8'hFB, 0);
        add(132,  0,  1, 0, 0, 0,    1, 8'hFF, 0);
        add(133,  0,  1, 0, 0, 0,    1, 8'hFB, 0);
        add(134,  0,  1, 0, 0, 0,    1, 8'hFB, 0);
        add(135,  1,  1, 0, 0, 1,    1, 8'hFB, 0);
        add(155,  0,  1, 0, 0, 1,    1, 8'hFB, 0);
        add(156,  0,  0, 1, 0, 0,    1, 8'hFB, 0);
        // restart coincident with lock loss in RUN
        add(160,  0,  0, 1, 0, 0,    0, 8'hFB, 0);
        add(162,  0,  0, 1, 0, 0,    0, 8'hFB, 1);
        add(163,  1,  1, 0, 0, 0,    1, 8'hFB, 0);
        add(170,  0,  1, 0, 0, 0,    1, 8'hFB, 0);
        add(183,  0,  1, 0, 0, 0,    1, 8'h00, 0);
        add(184,  0,  0, 1, 0, 0,    1, 8'h00, 0);

        // Reset values while rst is held
        repeat (2) @(posedge clk);
        #2;
        chk_out("reset", 0, 1, 1, 0, 0, 0);
        rst = 1'b0;
        last_edge = -1;

        for (int i = 0; i < vecs.size(); i++) begin
            go(vecs[i].e);
            chk_out("vec", i, vecs[i].dcm, vecs[i].sys, vecs[i].ok, vecs[i].flt, vecs[i].rty);
            dcm_locked = vecs[i].lk;
            dcm_status = vecs[i].st;
            restart    = vecs[i].rs;
        end

        // Asynchronous reset in the middle of SETTLE
        restart = 1'b1;
        step();
        restart = 1'b0;
        go(195);
        chk_out("mid_settle", 195, 0, 1, 0, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 0, 1, 1, 0, 0, 0);
        release_rst();
        go(3);
        chk_out("post_rst", 3, 0, 1, 0, 0, 0);
        go(19);
        chk_out("post_rst", 19, 0, 1, 0, 0, 0);
        go(20);
        chk_out("post_rst", 20, 0, 0, 1, 0, 0);

        // DCM never locks: three timed-out attempts end in FAULT
        dcm_locked = 1'b0;
        dcm_status = 8'h00;
        rst = 1'b1;
        release_rst();
        go(2);   chk_out("nolock", 2,   1, 1, 0, 0, 0);
        go(3);   chk_out("nolock", 3,   0, 1, 0, 0, 0);
        go(102); chk_out("nolock", 102, 0, 1, 0, 0, 0);
        go(103); chk_out("nolock", 103, 1, 1, 0, 0, 1);
        go(106); chk_out("nolock", 106, 1, 1, 0, 0, 1);
        go(107); chk_out("nolock", 107, 0, 1, 0, 0, 1);
        go(206); chk_out("nolock", 206, 0, 1, 0, 0, 1);
        go(207); chk_out("nolock", 207, 1, 1, 0, 0, 2);
        go(211); chk_out("nolock", 211, 0, 1, 0, 0, 2);
        go(310); chk_out("nolock", 310, 0, 1, 0, 0, 2);
        go(311); chk_out("nolock", 311, 1, 1, 0, 1, 3);
        go(400); chk_out("nolock", 400, 1, 1, 0, 1, 3);

        // Restart out of FAULT, then a normal lock
        restart    = 1'b1;
        dcm_locked = 1'b1;
        go(401); chk_out("fault_restart", 401, 1, 1, 0, 0, 0);
        restart = 1'b0;
        go(404); chk_out("fault_restart", 404, 1, 1, 0, 0, 0);
        go(405); chk_out("fault_restart", 405, 0, 1, 0, 0, 0);
        go(421); chk_out("fault_restart", 421, 0, 1, 0, 0, 0);
        go(422); chk_out("fault_restart", 422, 0, 0, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
